aixh_mxc_left_qtile_qcell: RTL
==============================

AIXH_MXC_LEFT_QTILE_QCELL -- requirements
Module: aixh_mxc_left_qtile_qcell

Interface
REQ-001 Parameters SHALL be:
- QDEPTH, default 4, queue entries; power of two, at least 2.
- LEN_W, default 8, width of the drain-length field.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- aixh_core_clk, in, 1: sole clock, rising edge.
- aixh_core_rstn, in, 1: reset, asynchronous, active-low.
- i_push_valid, in, 1: upstream word valid.
- o_push_ready, out, 1: queue can accept a word.
- i_push_data, in, LQCELL_BWD_DWIDTH: upstream word.
- i_drain_start, in, 1: request a drain burst.
- i_drain_len, in, LEN_W: number of words to drain.
- o_drain_busy, out, 1: a burst is in progress.
- o_wenable, out, 1: write strobe to the output-side cell.
- o_wdata, out, LQCELL_BWD_DWIDTH: write data to the output-side cell.
- o_count, out, $clog2(QDEPTH+1): current occupancy.
- o_err_underrun, out, 1: sticky underrun flag.
- i_err_clr, in, 1: clears o_err_underrun.

Function
REQ-003 A push SHALL occur on a cycle where i_push_valid and o_push_ready are both 1; the word is written at the write pointer, and the pointer wraps modulo QDEPTH.
REQ-004 o_push_ready SHALL equal (o_count < QDEPTH), evaluated on the registered count; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-005 The FSM SHALL have three states: IDLE, DRAIN, STALL; o_drain_busy SHALL be 1 in DRAIN and in STALL.
REQ-006 IDLE transition: i_drain_start with i_drain_len != 0 SHALL load remaining = i_drain_len and go to DRAIN; i_drain_len == 0 SHALL be a no-op.
REQ-007 i_drain_start while o_drain_busy is 1 SHALL be ignored.
REQ-008 DRAIN, o_count > 0: pop the head and decrement remaining; return to IDLE when remaining goes 1 -> 0.
REQ-009 DRAIN, o_count == 0: no pop, set o_err_underrun, go to STALL.
REQ-010 STALL: wait while o_count == 0; when o_count > 0, pop as in REQ-008, then go to DRAIN, or to IDLE if that pop was the last.
REQ-011 A word pushed in cycle N SHALL become poppable no earlier than cycle N+1; there is no write-to-read bypass.
REQ-012 Output timing:
- A pop in cycle N SHALL drive o_wenable = 1 and o_wdata = popped word in cycle N+1 (registered, one-cycle latency).
- o_wdata SHALL hold its last value while o_wenable is 0.
REQ-013 o_count SHALL update as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop; it SHALL never exceed QDEPTH or go below 0.
REQ-014 A push and a pop in the same cycle SHALL both take effect, and the pointers SHALL wrap independently.
REQ-015 If the underrun set condition and i_err_clr occur in the same cycle, set SHALL win.

Reset
REQ-016 While aixh_core_rstn = 0, asynchronously:
- FSM = IDLE; pointers, remaining and o_count = 0.
- o_wenable = 0, o_wdata = 0, o_err_underrun = 0, o_drain_busy = 0.
- o_push_ready = 1.
REQ-017 Queue storage SHALL NOT be reset.
REQ-018 A reset mid-burst SHALL discard all queued words and the remaining count.

Configuration
REQ-019 With AIXH_MXC_LQCELL_PARITY_EN defined:
- Each entry SHALL store an extra even-parity bit computed on push.
- On pop the parity SHALL be rechecked.
- A mismatch SHALL assert o_perr (1 bit, sticky, cleared by i_err_clr, reset 0) in the same cycle as the corresponding o_wenable.
REQ-020 Without AIXH_MXC_LQCELL_PARITY_EN, port o_perr and the parity storage SHALL be absent.

Structure
REQ-021 LQCELL_BWD_DWIDTH and the FSM state enum SHALL be defined in AIXH_MXC_pkg.
REQ-022 The storage and pointers SHALL be a single sub-module, aixh_mxc_lqcell_fifo; the FSM and output register SHALL live in the top module.

Verification
REQ-023 Push 0x11, 0x22, 0x33, then drain len=3 -> o_wenable high for 3 consecutive cycles, starting 1 cycle after the first pop, with data 0x11, 0x22, 0x33; o_count ends at 0; o_err_underrun = 0.
REQ-024 Push 4 words with QDEPTH=4 -> o_push_ready = 0; a 5th valid is held off; after one pop, ready returns the next cycle.
REQ-025 Push 1 word, drain len=3 -> 1 word out, FSM enters STALL, o_err_underrun = 1; push 2 more words -> 2 more strobes, then IDLE.
REQ-026 Push and pop every cycle for 20 cycles with QDEPTH=4 -> o_count constant, data order preserved across pointer wrap.
REQ-027 Assert reset mid-burst (remaining=5) -> all outputs at reset values immediately; after release o_count = 0 and a new drain start is accepted.
REQ-028 With AIXH_MXC_LQCELL_PARITY_EN defined, force-flip 1 stored bit -> o_perr = 1 with that word's o_wenable; i_err_clr -> o_perr = 0.

Source files
------------

// File: rtl/aixh_mxc_pkg.sv
// -----------------------------------------------------------------------------
// AIXH_MXC_pkg
//   Shared types and constants for the MXC left q-tile cell.
//   LQCELL_BWD_DWIDTH : data width of one queue word.
//   lqcell_state_e    : drain FSM states (IDLE / DRAIN / STALL).
//   lqcell_even_par() : even-parity bit over one queue word.
// -----------------------------------------------------------------------------
package AIXH_MXC_pkg;

  localparam int LQCELL_BWD_DWIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    STALL = 2'd2
  } lqcell_state_e;

  // XOR-reduce: the returned bit makes {data, par} an even-weight word.
  function automatic logic lqcell_even_par(input logic [LQCELL_BWD_DWIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/aixh_mxc_lqcell_fifo.sv
// -----------------------------------------------------------------------------
// aixh_mxc_lqcell_fifo
//   Circular word queue: storage, read/write pointers, occupancy count.
//   Storage is not reset; pointers and count reset asynchronously.
//   Ports:
//     aixh_core_clk, aixh_core_rstn : clock / async active-low reset
//     push, wdata                   : write one word (caller guarantees room)
//     pop                           : advance head (caller guarantees count>0)
//     rdata                         : head word (combinational read)
//     rperr                         : head entry fails parity recheck
//                                     (only with AIXH_MXC_LQCELL_PARITY_EN)
//     count                         : registered occupancy
//   Macro AIXH_MXC_LQCELL_PARITY_EN adds one even-parity bit per entry.
// -----------------------------------------------------------------------------
module aixh_mxc_lqcell_fifo
  import AIXH_MXC_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int DW     = LQCELL_BWD_DWIDTH,
  parameter int CW     = $clog2(QDEPTH+1)
) (
  input  logic          aixh_core_clk,
  input  logic          aixh_core_rstn,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
`ifdef AIXH_MXC_LQCELL_PARITY_EN
  output logic          rperr,
`endif
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(QDEPTH);
`ifdef AIXH_MXC_LQCELL_PARITY_EN
  localparam int EW = DW + 1;
`else
  localparam int EW = DW;
`endif

  logic [EW-1:0] mem [QDEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [EW-1:0] wentry;

`ifdef AIXH_MXC_LQCELL_PARITY_EN
  assign wentry = {lqcell_even_par(wdata), wdata};
  // Whole entry XORs to 0 when data and stored parity still agree.
  assign rperr  = ^mem[rptr];
`else
  assign wentry = wdata;
`endif

  assign rdata = mem[rptr][DW-1:0];

  always_ff @(posedge aixh_core_clk) begin
    if (push) mem[wptr] <= wentry;
  end

  // QDEPTH is a power of two, so natural AW-bit overflow is the wrap.
  always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
    if (!aixh_core_rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aixh_mxc_left_qtile_qcell.sv
// -----------------------------------------------------------------------------
// aixh_mxc_left_qtile_qcell
//   Word queue with a length-driven drain engine feeding an output-side cell.
//   Ports:
//     aixh_core_clk, aixh_core_rstn     : clock / async active-low reset
//     i_push_valid/o_push_ready/i_push_data : upstream word handshake
//     i_drain_start, i_drain_len        : request a burst of i_drain_len pops
//     o_drain_busy                      : burst in progress (DRAIN or STALL)
//     o_wenable, o_wdata                : registered write to output cell
//     o_count                           : queue occupancy
//     o_err_underrun, i_err_clr         : sticky underrun flag and its clear
//     o_perr                            : sticky parity error (parity build)
//   Macro AIXH_MXC_LQCELL_PARITY_EN enables per-entry parity and o_perr.
// -----------------------------------------------------------------------------
module aixh_mxc_left_qtile_qcell
  import AIXH_MXC_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int LEN_W  = 8
) (
  input  logic                         aixh_core_clk,
  input  logic                         aixh_core_rstn,
  input  logic                         i_push_valid,
  output logic                         o_push_ready,
  input  logic [LQCELL_BWD_DWIDTH-1:0] i_push_data,
  input  logic                         i_drain_start,
  input  logic [LEN_W-1:0]             i_drain_len,
  output logic                         o_drain_busy,
  output logic                         o_wenable,
  output logic [LQCELL_BWD_DWIDTH-1:0] o_wdata,
  output logic [$clog2(QDEPTH+1)-1:0]  o_count,
  output logic                         o_err_underrun,
`ifdef AIXH_MXC_LQCELL_PARITY_EN
  output logic                         o_perr,
`endif
  input  logic                         i_err_clr
);

  localparam int CW = $clog2(QDEPTH+1);

  lqcell_state_e                state, state_n;
  logic [LEN_W-1:0]             rem, rem_n;
  logic                         push, pop, uflow_set;
  logic [LQCELL_BWD_DWIDTH-1:0] head;
`ifdef AIXH_MXC_LQCELL_PARITY_EN
  logic                         head_perr;
`endif

  // Ready comes from the registered count only: a same-cycle pop does not
  // open a slot until the next cycle.
  assign o_push_ready = (o_count < CW'(QDEPTH));
  assign push         = i_push_valid & o_push_ready;
  assign o_drain_busy = (state != IDLE);

  aixh_mxc_lqcell_fifo #(
    .QDEPTH (QDEPTH),
    .DW     (LQCELL_BWD_DWIDTH),
    .CW     (CW)
  ) u_fifo (
    .aixh_core_clk  (aixh_core_clk),
    .aixh_core_rstn (aixh_core_rstn),
    .push           (push),
    .wdata          (i_push_data),
    .pop            (pop),
    .rdata          (head),
`ifdef AIXH_MXC_LQCELL_PARITY_EN
    .rperr          (head_perr),
`endif
    .count          (o_count)
  );

  always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
    if (!aixh_core_rstn) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  // Pops are gated on the registered count, so a word pushed this cycle is
  // never visible to the drain engine until the next one.
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    pop       = 1'b0;
    uflow_set = 1'b0;
    case (state)
      IDLE: begin
        if (i_drain_start && (i_drain_len != '0)) begin
          rem_n   = i_drain_len;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (o_count != '0) begin
          pop   = 1'b1;
          rem_n = rem - 1'b1;
          if (rem == LEN_W'(1)) state_n = IDLE;
        end else begin
          uflow_set = 1'b1;
          state_n   = STALL;
        end
      end
      STALL: begin
        if (o_count != '0) begin
          pop     = 1'b1;
          rem_n   = rem - 1'b1;
          state_n = (rem == LEN_W'(1)) ? IDLE : DRAIN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output register: strobe one cycle after the pop, data holds otherwise.
  always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
    if (!aixh_core_rstn) begin
      o_wenable <= 1'b0;
      o_wdata   <= '0;
    end else begin
      o_wenable <= pop;
      if (pop) o_wdata <= head;
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
    if (!aixh_core_rstn)  o_err_underrun <= 1'b0;
    else if (uflow_set)   o_err_underrun <= 1'b1;
    else if (i_err_clr)   o_err_underrun <= 1'b0;
  end

`ifdef AIXH_MXC_LQCELL_PARITY_EN
  // Registered alongside o_wenable so the flag rises with the bad word.
  always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
    if (!aixh_core_rstn)        o_perr <= 1'b0;
    else if (pop && head_perr)  o_perr <= 1'b1;
    else if (i_err_clr)         o_perr <= 1'b0;
  end
`endif

endmodule
